// File: rtl/accumulator_unit_pkg.sv
// accumulator_unit shared types
// widths, strobe bundle, AC-group arbitration
package accumulator_unit_pkg;

  localparam int WORD_W = 16;
  localparam int CHAR_W = 8;

  typedef struct packed {
    logic clr;
    logic inr;
    logic ld;
    logic op_and;
    logic op_add;
    logic op_dr;
    logic op_com;
    logic op_shr;
    logic op_shl;
    logic op_inpt;
    logic cle;
    logic cme;
  } ac_ctl_t;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_CLR,
    OP_INR,
    OP_AND,
    OP_ADD,
    OP_DR,
    OP_COM,
    OP_SHR,
    OP_SHL,
    OP_INPT
  } ac_op_e;

  function automatic ac_op_e ac_pick(ac_ctl_t c);
    if (c.clr)                 return OP_CLR;
    if (c.inr)                 return OP_INR;
    if (!c.ld)                 return OP_NONE;
    if (c.op_and)              return OP_AND;
    if (c.op_add)              return OP_ADD;
    if (c.op_dr)               return OP_DR;
    if (c.op_com)              return OP_COM;
    if (c.op_shr)              return OP_SHR;
    if (c.op_shl)              return OP_SHL;
    if (c.op_inpt)             return OP_INPT;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/accumulator_unit_if.sv
// accumulator_unit device handshake
// character in / character out channels
interface accumulator_unit_if
  import accumulator_unit_pkg::*;
();

  logic              IN_VALID;
  logic              IN_READY;
  logic [CHAR_W-1:0] IN_DATA;
  logic              OUT_VALID;
  logic              OUT_ACK;
  logic [CHAR_W-1:0] OUT_DATA;

  modport slave (
    input  IN_VALID,
    input  IN_DATA,
    input  OUT_ACK,
    output IN_READY,
    output OUT_VALID,
    output OUT_DATA
  );

  modport master (
    output IN_VALID,
    output IN_DATA,
    output OUT_ACK,
    input  IN_READY,
    input  OUT_VALID,
    input  OUT_DATA
  );

endinterface

// File: rtl/accumulator_unit_ac_alu.sv
// accumulator_unit next-state datapath
// arbitrates strobes, computes next {E, AC}
module ac_alu
  import accumulator_unit_pkg::*;
(
  input  ac_ctl_t           ctl,
  input  logic [WORD_W-1:0] ac,
  input  logic              e,
  input  logic [WORD_W-1:0] dr,
  input  logic [CHAR_W-1:0] inpr,
  output logic [WORD_W-1:0] ac_nxt,
  output logic              e_nxt,
  output logic              inpt_hit
);

  ac_op_e          op;
  logic [WORD_W:0] sum;

  // winner of AC arbitration drives AC; ADD/SHR/SHL also own E
  always_comb begin
    op       = ac_pick(ctl);
    sum      = {1'b0, ac} + {1'b0, dr};
    ac_nxt   = ac;
    e_nxt    = ctl.cle ? 1'b0 : (ctl.cme ? ~e : e);
    inpt_hit = 1'b0;
    unique case (op)
      OP_NONE: ac_nxt = ac;
      OP_CLR:  ac_nxt = '0;
      OP_INR:  ac_nxt = ac + 16'd1;
      OP_AND:  ac_nxt = ac & dr;
      OP_ADD: begin
        ac_nxt = sum[WORD_W-1:0];
        e_nxt  = sum[WORD_W];
      end
      OP_DR:   ac_nxt = dr;
      OP_COM:  ac_nxt = ~ac;
      OP_SHR: begin
        ac_nxt = {e, ac[WORD_W-1:1]};
        e_nxt  = ac[0];
      end
      OP_SHL: begin
        ac_nxt = {ac[WORD_W-2:0], e};
        e_nxt  = ac[WORD_W-1];
      end
      OP_INPT: begin
        ac_nxt   = {ac[WORD_W-1:CHAR_W], inpr};
        inpt_hit = 1'b1;
      end
      default: ac_nxt = ac;
    endcase
  end

endmodule

// File: rtl/accumulator_unit.sv
// accumulator_unit top
// AC/E registers, INPR/OUTR and device flags
module accumulator_unit
  import accumulator_unit_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              AND,
  input  logic              ADD,
  input  logic              DR,
  input  logic              COM,
  input  logic              SHR,
  input  logic              SHL,
  input  logic              INPT,
  input  logic              LD,
  input  logic              INR,
  input  logic              CLR,
  input  logic              CLE,
  input  logic              CME,
  input  logic              OUT,
  input  logic [WORD_W-1:0] DR_IN,
  output logic [WORD_W-1:0] AC,
  output logic              E,
  output logic              AC_ZERO,
  output logic              AC_NEG,
  output logic              FGI,
  output logic              FGO,
  accumulator_unit_if.slave io
);

  ac_ctl_t           ctl;
  logic [WORD_W-1:0] ac_nxt;
  logic              e_nxt;
  logic              inpt_hit;
  logic [CHAR_W-1:0] inpr;
  logic [CHAR_W-1:0] outr;
  logic              capture;

  assign ctl = '{
    clr:     CLR,
    inr:     INR,
    ld:      LD,
    op_and:  AND,
    op_add:  ADD,
    op_dr:   DR,
    op_com:  COM,
    op_shr:  SHR,
    op_shl:  SHL,
    op_inpt: INPT,
    cle:     CLE,
    cme:     CME
  };

  ac_alu u_alu (
    .ctl      (ctl),
    .ac       (AC),
    .e        (E),
    .dr       (DR_IN),
    .inpr     (inpr),
    .ac_nxt   (ac_nxt),
    .e_nxt    (e_nxt),
    .inpt_hit (inpt_hit)
  );

  assign AC_ZERO      = (AC == '0);
  assign AC_NEG       = AC[WORD_W-1];
  assign io.IN_READY  = ~FGI;
  assign io.OUT_VALID = ~FGO;
  assign io.OUT_DATA  = outr;
  assign capture      = io.IN_VALID & ~FGI;

  // accumulator and carry flip-flop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AC <= '0;
      E  <= 1'b0;
    end else begin
      AC <= ac_nxt;
      E  <= e_nxt;
    end
  end

  // input register; a capture can only occur while FGI is clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inpr <= '0;
      FGI  <= 1'b0;
    end else if (capture) begin
      inpr <= io.IN_DATA;
      FGI  <= 1'b1;
    end else if (inpt_hit) begin
      FGI  <= 1'b0;
    end
  end

  // output register; a fresh OUT beats a same-cycle ack
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      outr <= '0;
      FGO  <= 1'b1;
    end else if (OUT) begin
      outr <= AC[CHAR_W-1:0];
      FGO  <= 1'b0;
    end else if (io.OUT_ACK && !FGO) begin
      FGO  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accumulator_unit.sv
// accumulator_unit directed bench
// linear steps with immediate assertions
module tb_accumulator_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        AND = 0, ADD = 0, DR = 0, COM = 0;
  logic        SHR = 0, SHL = 0, INPT = 0, LD = 0;
  logic        INR = 0, CLR = 0, CLE = 0, CME = 0;
  logic        OUT = 0;
  logic [15:0] DR_IN = '0;
  logic [15:0] AC;
  logic        E, AC_ZERO, AC_NEG, FGI, FGO;

  int checks = 0;
  int errors = 0;

  accumulator_unit_if io();

  accumulator_unit dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .AND     (AND),
    .ADD     (ADD),
    .DR      (DR),
    .COM     (COM),
    .SHR     (SHR),
    .SHL     (SHL),
    .INPT    (INPT),
    .LD      (LD),
    .INR     (INR),
    .CLR     (CLR),
    .CLE     (CLE),
    .CME     (CME),
    .OUT     (OUT),
    .DR_IN   (DR_IN),
    .AC      (AC),
    .E       (E),
    .AC_ZERO (AC_ZERO),
    .AC_NEG  (AC_NEG),
    .FGI     (FGI),
    .FGO     (FGO),
    .io      (io.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    {AND, ADD, DR, COM, SHR, SHL, INPT} = '0;
    {LD, INR, CLR, CLE, CME, OUT} = '0;
    io.OUT_ACK = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    LD = 1; DR = 1; DR_IN = v;
    tick();
  endtask

  initial begin
    io.IN_VALID = 1'b0;
    io.IN_DATA  = '0;
    io.OUT_ACK  = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();

    load(16'h1234);
    chk("load_1234", AC, 16'h1234);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_ac", AC, 16'h0000);
    chk("rst_e", {15'd0, E}, 16'd0);
    chk("rst_fgi", {15'd0, FGI}, 16'd0);
    chk("rst_fgo", {15'd0, FGO}, 16'd1);
    chk("rst_zero", {15'd0, AC_ZERO}, 16'd1);
    chk("rst_oval", {15'd0, io.OUT_VALID}, 16'd0);
    chk("rst_irdy", {15'd0, io.IN_READY}, 16'd1);
    RST_N = 1'b1;
    tick();

    load(16'hFFFF);
    LD = 1; ADD = 1; DR_IN = 16'h0002;
    tick();
    chk("add_ac", AC, 16'h0001);
    chk("add_e", {15'd0, E}, 16'd1);
    LD = 1; SHR = 1;
    tick();
    chk("shr_ac", AC, 16'h8000);
    chk("shr_e", {15'd0, E}, 16'd1);
    chk("shr_neg", {15'd0, AC_NEG}, 16'd1);
    LD = 1; SHL = 1;
    tick();
    chk("shl_ac", AC, 16'h0001);
    chk("shl_e", {15'd0, E}, 16'd1);

    CLR = 1; INR = 1; LD = 1; DR = 1; DR_IN = 16'h1234;
    tick();
    chk("prio_clr", AC, 16'h0000);
    load(16'hFFFF);
    INR = 1;
    tick();
    chk("inr_wrap", AC, 16'h0000);
    chk("inr_e", {15'd0, E}, 16'd1);
    chk("inr_zero", {15'd0, AC_ZERO}, 16'd1);
    INR = 1;
    tick();
    INR = 1;
    tick();
    chk("inr_twice", AC, 16'h0002);

    load(16'hF0F0);
    LD = 1; AND = 1; ADD = 1; DR_IN = 16'h0FF0;
    tick();
    chk("and_over_add", AC, 16'h00F0);
    chk("and_e", {15'd0, E}, 16'd1);
    LD = 1; COM = 1;
    tick();
    chk("com", AC, 16'hFF0F);
    DR = 1; DR_IN = 16'h5555;
    tick();
    chk("no_ld", AC, 16'hFF0F);
    LD = 1;
    tick();
    chk("ld_only", AC, 16'hFF0F);

    io.IN_VALID = 1'b1; io.IN_DATA = 8'h41;
    tick();
    chk("in_fgi", {15'd0, FGI}, 16'd1);
    chk("in_rdy", {15'd0, io.IN_READY}, 16'd0);
    io.IN_DATA = 8'h42;
    load(16'hAB00);
    LD = 1; INPT = 1;
    tick();
    chk("inpt_ac", AC, 16'hAB41);
    chk("inpt_fgi", {15'd0, FGI}, 16'd0);
    tick();
    chk("recap_fgi", {15'd0, FGI}, 16'd1);
    io.IN_VALID = 1'b0;
    LD = 1; INPT = 1;
    tick();
    chk("recap_ac", AC, 16'hAB42);
    chk("recap_clr", {15'd0, FGI}, 16'd0);

    load(16'h00C3);
    OUT = 1;
    tick();
    chk("out_data", {8'd0, io.OUT_DATA}, 16'h00C3);
    chk("out_val", {15'd0, io.OUT_VALID}, 16'd1);
    io.OUT_ACK = 1'b1;
    tick();
    chk("ack_fgo", {15'd0, FGO}, 16'd1);
    load(16'h1255);
    OUT = 1; io.OUT_ACK = 1'b1;
    tick();
    chk("out_wins", {15'd0, FGO}, 16'd0);
    chk("out_data2", {8'd0, io.OUT_DATA}, 16'h0055);

    CLE = 1;
    tick();
    chk("cle", {15'd0, E}, 16'd0);
    CME = 1;
    tick();
    chk("cme", {15'd0, E}, 16'd1);
    CLE = 1; CME = 1;
    tick();
    chk("cle_cme", {15'd0, E}, 16'd0);
    load(16'h8000);
    LD = 1; ADD = 1; CLE = 1; DR_IN = 16'h8000;
    tick();
    chk("add_cle_ac", AC, 16'h0000);
    chk("add_cle_e", {15'd0, E}, 16'd1);
    load(16'h0001);
    LD = 1; ADD = 1; CME = 1; DR_IN = 16'h0001;
    tick();
    chk("add_cme_ac", AC, 16'h0002);
    chk("add_cme_e", {15'd0, E}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
